positron_window_arbiter: RTL and testbench
==========================================

POSITRON_WINDOW_ARBITER -- requirements
Module: positron_window_arbiter

Interface
REQ-001 SHALL have parameter POSIT_WIDTH, default 16, width of one posit.
REQ-002 SHALL have parameter NB_REQ, default 4, number of requesters (2..16).
REQ-003 SHALL have parameter TAG_DEPTH, default 4, number of outstanding windows tracked (power of 2).
REQ-004 SHALL have port clk  in  1  system clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports req_rts_i, req_sow_i, req_eow_i  in  NB_REQ  per-requester slave controls.
REQ-007 SHALL have port req_data_i  in  NB_REQ*2*POSIT_WIDTH  per-requester {weight,activation}; activation in LSB posit.
REQ-008 SHALL have port req_rtr_o  out  NB_REQ  per-requester ready.
REQ-009 SHALL have ports eng_rts_o, eng_sow_o, eng_eow_o  out  1, eng_data_o  out  2*POSIT_WIDTH, eng_rtr_i  in  1: stream to the dot-product engine.
REQ-010 SHALL have ports eng_rts_i  in  1, eng_posit_i  in  POSIT_WIDTH, eng_rtr_o  out  1: one result per window from the engine.
REQ-011 SHALL have ports res_rts_o  out  NB_REQ, res_posit_o  out  POSIT_WIDTH, res_rtr_i  in  NB_REQ: result return.
REQ-012 SHALL have ports grant_o  out  clog2(NB_REQ)  current/last grant; busy_o  out  1  in STREAM; orphan_o  out  1  sticky error.

Function
REQ-013 SHALL implement FSM IDLE, STREAM; a transfer is rts&rtr on the same cycle.
REQ-014 In IDLE, if any req_rts_i set and tag FIFO not full, SHALL register grant = first requesting index round-robin from last_grant+1 and enter STREAM next cycle.
REQ-015 In IDLE, all req_rtr_o and eng_rts_o SHALL be 0.
REQ-016 In STREAM, eng_rts_o/eng_eow_o/eng_data_o SHALL combinationally equal the granted requester's inputs; req_rtr_o[grant]=eng_rtr_i; other req_rtr_o=0.
REQ-017 eng_sow_o SHALL be 1 on the first transfer of a grant regardless of req_sow_i, 0 otherwise.
REQ-018 Grant SHALL stay locked until the eow transfer; then push grant into tag FIFO, last_grant<=grant, return to IDLE.
REQ-019 Minimum gap between windows SHALL be one cycle (IDLE arbitration cycle); no beat is transferred in IDLE.
REQ-020 With tag FIFO empty, eng_rtr_o=0, res_rts_o=0; a cycle with eng_rts_i=1 while empty SHALL set orphan_o.
REQ-021 Otherwise res_rts_o[head]=eng_rts_i, other bits 0, res_posit_o=eng_posit_i, eng_rtr_o=res_rtr_i[head]; pop on eng_rts_i&eng_rtr_o.
REQ-022 Simultaneous push and pop SHALL both occur, count unchanged; full check at grant time suffices since only one push per window.
REQ-023 Results SHALL return to requesters in window-completion order (FIFO order).
REQ-024 Single-requester case SHALL re-grant the same index after each window.

Reset
REQ-025 On rst: state IDLE, last_grant=NB_REQ-1 (so index 0 wins first), grant_o=0, tag FIFO empty, busy_o=0, orphan_o=0, all req_rtr_o, eng_rts_o, eng_sow_o, eng_eow_o, eng_rtr_o, res_rts_o=0; eng_data_o, res_posit_o combinational pass-through.
REQ-026 Reset mid-window SHALL drop the window and all tags; requesters restart from sow.

Structure
REQ-027 Tag width and state enum SHALL be defined in shared package posit_defines.
REQ-028 Tag FIFO SHALL be a separate sub-module posit_tag_fifo (TAG_DEPTH x clog2(NB_REQ), full/empty, same-cycle push+pop).

Verification
REQ-029 Reset, req_rts_i=4'b0101 held -> grants 0,2,0,2; each window 3 beats; eng_sow_o on beat 1 only; 1 idle cycle between windows.
REQ-030 Requester 1 window with req_sow_i=0 on beat 1 -> eng_sow_o=1 on beat 1.
REQ-031 eng_rtr_i=0 for 5 cycles mid-window -> req_rtr_o[grant]=0, no data lost, grant unchanged.
REQ-032 Engine withholds results, 4 windows completed (TAG_DEPTH=4) -> fifth request not granted until first result popped; results routed to 0,1,2,3 in order.
REQ-033 eng_rts_i=1 with empty FIFO -> eng_rtr_o=0, orphan_o=1 held until rst.
REQ-034 rst asserted during beat 2 of window -> next cycle all outputs per REQ-025, next grant to index 0.

Source files
------------

// File: rtl/posit_defines.sv
// Shared types for the positron window arbiter: FSM states and tag sizing.
package posit_defines;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } arb_state_t;

    // A tag names a requester, so it is as wide as a requester index.
    function automatic int tag_width(input int nb_req);
        return (nb_req > 1) ? $clog2(nb_req) : 1;
    endfunction

endpackage

// File: rtl/posit_tag_fifo.sv
// Small FIFO of requester tags for windows awaiting an engine result; head is visible combinationally.
module posit_tag_fifo
    import posit_defines::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_tag,
    input  logic             pop,
    output logic [WIDTH-1:0] head_tag,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty    = (count_reg == '0);
    assign do_pop   = pop && !empty;
    // A push into a full FIFO is only legal when the head leaves on the same edge.
    assign do_push  = push && (!full || do_pop);
    assign head_tag = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/positron_window_arbiter.sv
// Round-robin window arbiter feeding one dot-product engine and routing each result back
// to the requester whose window produced it, in window-completion order.
module positron_window_arbiter
    import posit_defines::*;
#(
    parameter int POSIT_WIDTH = 16,
    parameter int NB_REQ      = 4,
    parameter int TAG_DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NB_REQ-1:0]               req_rts_i,
    input  logic [NB_REQ-1:0]               req_sow_i,
    input  logic [NB_REQ-1:0]               req_eow_i,
    input  logic [NB_REQ*2*POSIT_WIDTH-1:0] req_data_i,
    output logic [NB_REQ-1:0]               req_rtr_o,
    output logic                            eng_rts_o,
    output logic                            eng_sow_o,
    output logic                            eng_eow_o,
    output logic [2*POSIT_WIDTH-1:0]        eng_data_o,
    input  logic                            eng_rtr_i,
    input  logic                            eng_rts_i,
    input  logic [POSIT_WIDTH-1:0]          eng_posit_i,
    output logic                            eng_rtr_o,
    output logic [NB_REQ-1:0]               res_rts_o,
    output logic [POSIT_WIDTH-1:0]          res_posit_o,
    input  logic [NB_REQ-1:0]               res_rtr_i,
    output logic [$clog2(NB_REQ)-1:0]       grant_o,
    output logic                            busy_o,
    output logic                            orphan_o
);
    localparam int TAG_W = tag_width(NB_REQ);
    localparam int DW    = 2 * POSIT_WIDTH;

    arb_state_t       state_reg, state_next;
    logic [TAG_W-1:0] grant_reg, grant_next;
    logic [TAG_W-1:0] last_grant_reg, last_grant_next;
    logic             first_reg, first_next;
    logic             orphan_reg;

    logic [DW-1:0]    req_data_arr [NB_REQ];
    logic [TAG_W-1:0] pick_idx;
    logic [TAG_W-1:0] cand;
    logic             pick_valid;
    logic             busy;
    logic             beat_xfer;
    logic             tag_push;
    logic             tag_pop;
    logic             tag_full;
    logic             tag_empty;
    logic [TAG_W-1:0] head_tag;
    logic             unused_sow;

    // The engine sees start-of-window from our own first-beat flag, not the requester's.
    assign unused_sow = ^req_sow_i;

    generate
        for (genvar gi = 0; gi < NB_REQ; gi++) begin : g_req
            assign req_data_arr[gi] = req_data_i[gi*DW +: DW];
            assign req_rtr_o[gi]    = busy && (grant_reg == TAG_W'(gi)) && eng_rtr_i;
            assign res_rts_o[gi]    = !tag_empty && (head_tag == TAG_W'(gi)) && eng_rts_i;
        end
    endgenerate

    assign busy       = (state_reg == ST_STREAM);
    assign eng_data_o = req_data_arr[grant_reg];
    assign eng_rts_o  = busy && req_rts_i[grant_reg];
    assign eng_eow_o  = busy && req_eow_i[grant_reg];
    assign eng_sow_o  = eng_rts_o && first_reg;
    assign beat_xfer  = eng_rts_o && eng_rtr_i;
    assign tag_push   = beat_xfer && eng_eow_o;

    assign eng_rtr_o   = !tag_empty && res_rtr_i[head_tag];
    assign res_posit_o = eng_posit_i;
    assign tag_pop     = eng_rts_i && eng_rtr_o;

    assign grant_o  = grant_reg;
    assign busy_o   = busy;
    assign orphan_o = orphan_reg;

    // Scan from the farthest candidate inward so the nearest requester after last_grant wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NB_REQ; k >= 1; k--) begin
            cand = TAG_W'((int'(last_grant_reg) + k) % NB_REQ);
            if (req_rts_i[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        first_next      = first_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_valid && !tag_full) begin
                    grant_next = pick_idx;
                    first_next = 1'b1;
                    state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (beat_xfer) begin
                    first_next = 1'b0;
                    if (eng_eow_o) begin
                        last_grant_next = grant_reg;
                        state_next      = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            grant_reg      <= '0;
            last_grant_reg <= TAG_W'(NB_REQ - 1);
            first_reg      <= 1'b0;
            orphan_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            first_reg      <= first_next;
            if (eng_rts_i && tag_empty) begin
                orphan_reg <= 1'b1;
            end
        end
    end

    posit_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .WIDTH (TAG_W)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (tag_push),
        .push_tag (grant_reg),
        .pop      (tag_pop),
        .head_tag (head_tag),
        .full     (tag_full),
        .empty    (tag_empty)
    );

endmodule

// File: tb/tb_positron_window_arbiter.sv
// Directed and randomized checks of the window arbiter against a transaction-level model
// of requester windows, round-robin order and result routing.
module tb_positron_window_arbiter;
    localparam int PW = 16;
    localparam int NR = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req_rts = '0, req_sow = '0, req_eow = '0;
    logic [NR*32-1:0] req_data = '0;
    logic [NR-1:0]   req_rtr_o;
    logic            eng_rts_o, eng_sow_o, eng_eow_o;
    logic [31:0]     eng_data_o;
    logic            eng_rtr_i = 1'b1;
    logic            eng_rts_i = 1'b0;
    logic [PW-1:0]   eng_posit_i = '0;
    logic            eng_rtr_o;
    logic [NR-1:0]   res_rts_o;
    logic [PW-1:0]   res_posit_o;
    logic [NR-1:0]   res_rtr_i = '1;
    logic [1:0]      grant_o;
    logic            busy_o, orphan_o;

    positron_window_arbiter #(.POSIT_WIDTH(PW), .NB_REQ(NR), .TAG_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .req_rts_i(req_rts), .req_sow_i(req_sow), .req_eow_i(req_eow), .req_data_i(req_data),
        .req_rtr_o(req_rtr_o),
        .eng_rts_o(eng_rts_o), .eng_sow_o(eng_sow_o), .eng_eow_o(eng_eow_o),
        .eng_data_o(eng_data_o), .eng_rtr_i(eng_rtr_i),
        .eng_rts_i(eng_rts_i), .eng_posit_i(eng_posit_i), .eng_rtr_o(eng_rtr_o),
        .res_rts_o(res_rts_o), .res_posit_o(res_posit_o), .res_rtr_i(res_rtr_i),
        .grant_o(grant_o), .busy_o(busy_o), .orphan_o(orphan_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Requester sources: windows still to send, beats per window, beat position, current beat data.
    int          rem [NR];
    int          len [NR];
    int          beat [NR];
    logic [31:0] cur [NR];
    bit          sow_en [NR];

    // Reference model state.
    int model_last = NR - 1;
    int cur_grant  = 0;
    bit in_window  = 0;
    bit orphan_exp = 0;
    bit gap_check  = 0;
    int cyc = 0;
    int last_eow_cyc = -1;
    int done_q[$];
    int grant_log[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NR-1:0] active_mask();
        logic [NR-1:0] m;
        for (int i = 0; i < NR; i++) m[i] = (rem[i] > 0);
        return m;
    endfunction

    function automatic int rr_next(input int last, input logic [NR-1:0] m);
        for (int k = 1; k <= NR; k++) begin
            if (m[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    task automatic drive_src();
        for (int i = 0; i < NR; i++) begin
            req_rts[i] = (rem[i] > 0);
            req_sow[i] = (beat[i] == 0) && sow_en[i];
            req_eow[i] = (beat[i] == len[i] - 1);
            req_data[i*32 +: 32] = cur[i];
        end
    endtask

    // One clock: check the settled cycle, advance model and sources across the edge.
    task automatic tick();
        bit xfer;
        bit last_beat;
        int g;
        int h;
        #1;
        chk("orphan", {63'b0, orphan_o}, {63'b0, orphan_exp});
        if (!busy_o) chk("idle_quiet", {59'b0, eng_rts_o, req_rtr_o}, 64'd0);
        xfer = eng_rts_o && eng_rtr_i;
        g = cur_grant;
        last_beat = 0;
        if (xfer) begin
            if (!in_window) begin
                cur_grant = rr_next(model_last, active_mask());
                g = cur_grant;
                grant_log.push_back(g);
                chk("grant", 64'(grant_o), 64'(g));
                chk("sow_first", {63'b0, eng_sow_o}, 64'd1);
                if (gap_check && last_eow_cyc >= 0) chk("gap", 64'(cyc - last_eow_cyc), 64'd2);
                in_window = 1;
            end else begin
                chk("grant_lock", 64'(grant_o), 64'(g));
                chk("sow_later", {63'b0, eng_sow_o}, 64'd0);
            end
            last_beat = (beat[g] == len[g] - 1);
            chk("data", 64'(eng_data_o), 64'(cur[g]));
            chk("eow", {63'b0, eng_eow_o}, {63'b0, last_beat});
            chk("req_rtr", 64'(req_rtr_o), 64'(1 << g));
        end
        if (done_q.size() == 0) begin
            chk("eng_rtr_empty", {63'b0, eng_rtr_o}, 64'd0);
            chk("res_rts_empty", 64'(res_rts_o), 64'd0);
            if (eng_rts_i) orphan_exp = 1;
        end else begin
            h = done_q[0];
            chk("res_rts", 64'(res_rts_o), eng_rts_i ? 64'(1 << h) : 64'd0);
            chk("res_posit", 64'(res_posit_o), 64'(eng_posit_i));
            chk("eng_rtr", {63'b0, eng_rtr_o}, {63'b0, res_rtr_i[h]});
            if (eng_rts_i && res_rtr_i[h]) void'(done_q.pop_front());
        end
        if (xfer && last_beat) begin
            done_q.push_back(g);
            model_last = g;
            in_window = 0;
            last_eow_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (xfer) begin
            if (last_beat) begin
                beat[g] = 0;
                rem[g]--;
            end else begin
                beat[g]++;
            end
            cur[g] = $urandom;
        end
        drive_src();
        @(negedge clk);
    endtask

    task automatic run_windows(input bit rnd);
        int n = 0;
        while ((active_mask() != '0 || in_window) && n < 1000) begin
            if (rnd) begin
                eng_rtr_i   = ($urandom % 4) != 0;
                eng_rts_i   = (done_q.size() > 0) && ($urandom % 2 == 1);
                res_rtr_i   = NR'($urandom);
                eng_posit_i = PW'($urandom);
            end
            tick();
            n++;
        end
        chk("run_timeout", 64'(n < 1000), 64'd1);
        eng_rtr_i = 1'b1;
        eng_rts_i = 1'b0;
        res_rtr_i = '1;
    endtask

    task automatic drain();
        int n = 0;
        res_rtr_i = '1;
        while (done_q.size() > 0 && n < 50) begin
            eng_rts_i   = 1'b1;
            eng_posit_i = PW'($urandom);
            tick();
            n++;
        end
        chk("drain_timeout", 64'(n < 50), 64'd1);
        eng_rts_i = 1'b0;
    endtask

    task automatic reset_outputs_check();
        chk("rst_busy", {63'b0, busy_o}, 64'd0);
        chk("rst_orphan", {63'b0, orphan_o}, 64'd0);
        chk("rst_grant", 64'(grant_o), 64'd0);
        chk("rst_req_rtr", 64'(req_rtr_o), 64'd0);
        chk("rst_eng_ctl", {61'b0, eng_rts_o, eng_sow_o, eng_eow_o}, 64'd0);
        chk("rst_eng_rtr", {63'b0, eng_rtr_o}, 64'd0);
        chk("rst_res_rts", 64'(res_rts_o), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            rem[i] = 0; len[i] = 3; beat[i] = 0; cur[i] = $urandom; sow_en[i] = 1;
        end
        drive_src();

        // Reset state, including pass-through paths.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        eng_rts_i = 1'b1;
        eng_posit_i = PW'($urandom);
        #1;
        reset_outputs_check();
        chk("rst_posit_pass", 64'(res_posit_o), 64'(eng_posit_i));
        chk("rst_data_pass", 64'(eng_data_o), 64'(cur[0]));
        eng_rts_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);

        // Two requesters held: grants alternate 0,2,0,2 with one idle cycle between windows.
        gap_check = 1;
        last_eow_cyc = -1;
        rem[0] = 2; rem[2] = 2;
        drive_src();
        run_windows(0);
        gap_check = 0;
        chk("alt_count", 64'(grant_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) chk("alt_order", 64'(grant_log[i]), (i % 2 == 0) ? 64'd0 : 64'd2);
        drain();

        // Requester 1 leaves its own sow low; the engine still sees a window start.
        grant_log.delete();
        rem[1] = 1; len[1] = 2; sow_en[1] = 0;
        drive_src();
        run_windows(0);
        chk("nosow_grant", 64'(grant_log[0]), 64'd1);
        sow_en[1] = 1;
        drain();

        // Engine backpressure for five cycles in the middle of a window.
        rem[3] = 1; len[3] = 4;
        drive_src();
        for (int n = 0; n < 20 && !(in_window && beat[3] == 2); n++) tick();
        eng_rtr_i = 1'b0;
        repeat (5) begin
            #1;
            chk("stall_req_rtr", 64'(req_rtr_o), 64'd0);
            chk("stall_grant", 64'(grant_o), 64'd3);
            tick();
        end
        eng_rtr_i = 1'b1;
        run_windows(0);
        drain();

        // Four completed windows fill the tag FIFO; a fifth waits for the first pop.
        grant_log.delete();
        for (int i = 0; i < NR; i++) begin
            rem[i] = 1; len[i] = 1 + ($urandom % 3);
        end
        drive_src();
        run_windows(0);
        chk("full_count", 64'(done_q.size()), 64'd4);
        rem[0] = 1;
        drive_src();
        repeat (6) begin
            #1;
            chk("full_hold_busy", {63'b0, busy_o}, 64'd0);
            tick();
        end
        eng_rts_i = 1'b1;
        eng_posit_i = PW'($urandom);
        tick();
        eng_rts_i = 1'b0;
        run_windows(0);
        drain();
        for (int i = 0; i < 5; i++) chk("full_order", 64'(grant_log[i]), 64'(i % NR));

        // Randomized rounds with engine stalls and result backpressure.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NR; i++) begin
                rem[i] = $urandom_range(0, 2);
                len[i] = $urandom_range(1, 4);
                sow_en[i] = $urandom_range(0, 1);
            end
            if (active_mask() == '0) rem[r % NR] = 1;
            drive_src();
            run_windows(1);
            drain();
        end

        // Result from the engine with no window outstanding.
        eng_rts_i = 1'b1;
        #1;
        chk("orphan_rtr", {63'b0, eng_rtr_o}, 64'd0);
        tick();
        eng_rts_i = 1'b0;
        repeat (3) tick();
        chk("orphan_sticky", {63'b0, orphan_o}, 64'd1);

        // Reset in beat 2 of a window drops the window and the pending tag.
        rem[0] = 1; len[0] = 2;
        drive_src();
        run_windows(0);
        rem[3] = 1; len[3] = 4;
        drive_src();
        for (int n = 0; n < 20 && !(in_window && beat[3] == 1); n++) tick();
        chk("pre_rst_grant", 64'(grant_o), 64'd3);
        rst = 1'b1;
        res_rtr_i = '1;
        @(posedge clk);
        @(negedge clk);
        #1;
        reset_outputs_check();
        for (int i = 0; i < NR; i++) begin
            rem[i] = 0; beat[i] = 0;
        end
        done_q.delete();
        grant_log.delete();
        in_window = 0;
        model_last = NR - 1;
        orphan_exp = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rem[0] = 1; rem[3] = 1; len[0] = 2; len[3] = 2;
        drive_src();
        @(negedge clk);
        run_windows(0);
        chk("post_rst_first", 64'(grant_log[0]), 64'd0);
        chk("post_rst_second", 64'(grant_log[1]), 64'd3);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
